prog_mem_ctrl: RTL and testbench

PROG_MEM_CTRL -- requirements
Module: prog_mem_ctrl

---
 rtl/prog_mem_ctrl.sv | 146 ++++++++++++++
 tb/tb_prog_mem_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_mem_ctrl.sv
// Program memory controller: serves pipelined core instruction fetches and, on request,
// assembles a byte-serial program image into 32-bit words written to memory.
module prog_mem_ctrl #(
  parameter int ADDR_WIDTH  = 11,
  parameter int MEM_DEPTH   = 512,
  parameter int BIG_END_IMG = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_valid,
  output logic [31:0]           fetch_data,
  output logic                  fetch_err,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  input  logic                  ld_last,
  input  logic [7:0]            ld_byte,
  output logic                  ld_ready,
  output logic                  ld_done,
  output logic                  ld_overflow,
  output logic                  core_hold,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic [1:0]            dbg_state
);

  localparam int WA = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_e;

  state_e          state_q, state_d;
  logic [WA-1:0]   wcnt_q, wcnt_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [31:0]     word_q, word_d;
  logic            last_q, last_d;
  logic            ovf_q, ovf_d;
  logic            fvalid_q, ferr_q;
  logic            grant;

  // Loader handshake: a byte transfers on any cycle where ld_valid and ld_ready are both high.
  // Grant is gated by rst_n so it drops the moment reset asserts, like the registered outputs.
  assign grant = rst_n && (state_q == IDLE) && fetch_req && !ld_start;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    last_d  = last_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (ld_start) begin
          state_d = COLLECT;
          wcnt_d  = '0;
          bcnt_d  = '0;
          word_d  = '0;
          last_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      COLLECT: begin
        if (ld_valid) begin
          case (bcnt_q)
            2'd0:    word_d[31:24] = ld_byte;
            2'd1:    word_d[23:16] = ld_byte;
            2'd2:    word_d[15:8]  = ld_byte;
            default: word_d[7:0]   = ld_byte;
          endcase
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3 || ld_last) begin
            state_d = WRITE;
            last_d  = ld_last;
          end
        end
      end
      WRITE: begin
        if (wcnt_q == WA'(MEM_DEPTH - 1)) begin
          wcnt_d = '0;
          ovf_d  = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WA'(1);
        end
        bcnt_d  = '0;
        word_d  = '0;
        state_d = last_q ? DONE : COLLECT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      bcnt_q   <= '0;
      word_q   <= '0;
      last_q   <= 1'b0;
      ovf_q    <= 1'b0;
      fvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      bcnt_q   <= bcnt_d;
      word_q   <= word_d;
      last_q   <= last_d;
      ovf_q    <= ovf_d;
      fvalid_q <= grant;
      ferr_q   <= grant && (fetch_addr[1:0] != 2'b00);
    end
  end

  always_comb begin
    fetch_gnt   = grant;
    mem_re      = grant;
    mem_we      = (state_q == WRITE);
    mem_addr    = '0;
    mem_wdata   = '0;
    if (grant) begin
      mem_addr = fetch_addr[ADDR_WIDTH-1:2];
    end else if (state_q == WRITE) begin
      mem_addr  = wcnt_q;
      mem_wdata = word_q;
    end
    fetch_valid = fvalid_q;
    fetch_err   = ferr_q;
    fetch_data  = '0;
    // Memory returns read data the cycle after mem_re, which lines up with fetch_valid.
    if (fvalid_q) begin
      fetch_data = (BIG_END_IMG != 0) ? mem_rdata
                 : {mem_rdata[7:0], mem_rdata[15:8], mem_rdata[23:16], mem_rdata[31:24]};
    end
    ld_ready    = (state_q == COLLECT);
    ld_done     = (state_q == DONE);
    ld_overflow = ovf_q;
    core_hold   = (state_q != IDLE);
    dbg_state   = state_q;
  end

endmodule

// File: tb/tb_prog_mem_ctrl.sv
// Bench for prog_mem_ctrl: per-cycle vector table for load/fetch behaviour, then
// directed sequences for address wrap/overflow and reset in the middle of a word.
module tb_prog_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        fetch_req;
  logic [10:0] fetch_addr;
  logic        fetch_gnt, fetch_valid, fetch_err;
  logic [31:0] fetch_data;
  logic        ld_start, ld_valid, ld_last;
  logic [7:0]  ld_byte;
  logic        ld_ready, ld_done, ld_overflow, core_hold;
  logic [8:0]  mem_addr;
  logic        mem_re, mem_we;
  logic [31:0] mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [512];
  logic [40:0] exp_q[$];

  prog_mem_ctrl #(.ADDR_WIDTH(11), .MEM_DEPTH(512), .BIG_END_IMG(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_err(fetch_err),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_last(ld_last), .ld_byte(ld_byte),
    .ld_ready(ld_ready), .ld_done(ld_done), .ld_overflow(ld_overflow), .core_hold(core_hold),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read memory behind the controller
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[2] = 32'h01234567;
    mem_rdata = 32'h0;
  end

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic        fr;
    logic [10:0] fa;
    logic        ls, lv, ll;
    logic [7:0]  lb;
    logic        gnt, re;
    logic [8:0]  maddr;
    logic        fv;
    logic [31:0] fdata;
    logic        ferr, rdy, hold, done, we;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs [26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Driver: apply one cycle of inputs at the falling edge, then score any memory write.
  task automatic drive(input logic fr, input logic [10:0] fa, input logic ls,
                       input logic lv, input logic ll, input logic [7:0] lb);
    logic [40:0] e;
    fetch_req = fr; fetch_addr = fa; ld_start = ls;
    ld_valid = lv; ld_last = ll; ld_byte = lb;
    #1;
    chk("re_we_exclusive", {31'h0, mem_re & mem_we}, 32'h0);
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {23'h0, mem_addr}, 32'h1ff);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", {23'h0, mem_addr}, {23'h0, e[40:32]});
        chk("write_data", mem_wdata, e[31:0]);
      end
    end
  endtask

  task automatic idle_cycle();
    drive(1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    logic [31:0] w;
    //            fr fa     ls lv ll lb      gnt re maddr fv fdata         ferr rdy hold done we wdata
    vecs[0]  = '{0, 11'd0, 0, 0, 0, 8'h00,  0, 0, 9'd0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0};
    vecs[1]  = '{0, 11'd0, 1, 0, 0, 8'h00,  0, 0, 9'd0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0};
    vecs[2]  = '{0, 11'd0, 0, 1, 0, 8'h13,  0, 0, 9'd0, 0, 32'h0,        0, 1, 1, 0, 0, 32'h0};
    vecs[3]  = '{0, 11'd0, 0, 1, 0, 8'h00,  0, 0, 9'd0, 0, 32'h0,        0, 1, 1, 0, 0, 32'h0};
    vecs[4]  = '{0, 11'd0, 0, 1, 0, 8'h00,  0, 0, 9'd0, 0, 32'h0,        0, 1, 1, 0, 0, 32'h0};
    vecs[5]  = '{0, 11'd0, 0, 1, 1, 8'h93,  0, 0, 9'd0, 0, 32'h0,        0, 1, 1, 0, 0, 32'h0};
    vecs[6]  = '{0, 11'd0, 0, 0, 0, 8'h00,  0, 0, 9'd0, 0, 32'h0,        0, 0, 1, 0, 1, 32'h13000093};
    vecs[7]  = '{0, 11'd0, 0, 0, 0, 8'h00,  0, 0, 9'd0, 0, 32'h0,        0, 0, 1, 1, 0, 32'h0};
    vecs[8]  = '{1, 11'd0, 0, 0, 0, 8'h00,  1, 1, 9'd0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0};
    vecs[9]  = '{1, 11'd0, 0, 0, 0, 8'h00,  1, 1, 9'd0, 1, 32'h93000013, 0, 0, 0, 0, 0, 32'h0};
    vecs[10] = '{1, 11'd4, 1, 0, 0, 8'h00,  0, 0, 9'd0, 1, 32'h93000013, 0, 0, 0, 0, 0, 32'h0};
    vecs[11] = '{0, 11'd0, 0, 1, 0, 8'hAA,  0, 0, 9'd0, 0, 32'h0,        0, 1, 1, 0, 0, 32'h0};
    vecs[12] = '{0, 11'd0, 0, 1, 0, 8'hBB,  0, 0, 9'd0, 0, 32'h0,        0, 1, 1, 0, 0, 32'h0};
    vecs[13] = '{0, 11'd0, 0, 1, 0, 8'hCC,  0, 0, 9'd0, 0, 32'h0,        0, 1, 1, 0, 0, 32'h0};
    vecs[14] = '{0, 11'd0, 0, 1, 0, 8'hDD,  0, 0, 9'd0, 0, 32'h0,        0, 1, 1, 0, 0, 32'h0};
    vecs[15] = '{0, 11'd0, 0, 1, 0, 8'hEE,  0, 0, 9'd0, 0, 32'h0,        0, 0, 1, 0, 1, 32'hAABBCCDD};
    vecs[16] = '{0, 11'd0, 0, 1, 0, 8'h11,  0, 0, 9'd0, 0, 32'h0,        0, 1, 1, 0, 0, 32'h0};
    vecs[17] = '{0, 11'd0, 0, 1, 1, 8'h22,  0, 0, 9'd0, 0, 32'h0,        0, 1, 1, 0, 0, 32'h0};
    vecs[18] = '{0, 11'd0, 0, 0, 0, 8'h00,  0, 0, 9'd1, 0, 32'h0,        0, 0, 1, 0, 1, 32'h11220000};
    vecs[19] = '{1, 11'd0, 1, 0, 0, 8'h00,  0, 0, 9'd0, 0, 32'h0,        0, 0, 1, 1, 0, 32'h0};
    vecs[20] = '{1, 11'd0, 0, 0, 0, 8'h00,  1, 1, 9'd0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0};
    vecs[21] = '{1, 11'd4, 0, 0, 0, 8'h00,  1, 1, 9'd1, 1, 32'hDDCCBBAA, 0, 0, 0, 0, 0, 32'h0};
    vecs[22] = '{1, 11'd8, 0, 0, 0, 8'h00,  1, 1, 9'd2, 1, 32'h00002211, 0, 0, 0, 0, 0, 32'h0};
    vecs[23] = '{1, 11'd6, 0, 0, 0, 8'h00,  1, 1, 9'd1, 1, 32'h67452301, 0, 0, 0, 0, 0, 32'h0};
    vecs[24] = '{0, 11'd0, 0, 0, 0, 8'h00,  0, 0, 9'd0, 1, 32'h00002211, 1, 0, 0, 0, 0, 32'h0};
    vecs[25] = '{0, 11'd0, 0, 0, 0, 8'h00,  0, 0, 9'd0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0};

    exp_q.push_back({9'd0, 32'h13000093});
    exp_q.push_back({9'd0, 32'hAABBCCDD});
    exp_q.push_back({9'd1, 32'h11220000});

    rst_n = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0; ld_start = 1'b0;
    ld_valid = 1'b0; ld_last = 1'b0; ld_byte = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: one row per clock cycle
    for (int i = 0; i < 26; i++) begin
      v = vecs[i];
      drive(v.fr, v.fa, v.ls, v.lv, v.ll, v.lb);
      chk($sformatf("r%0d_gnt", i),   {31'h0, fetch_gnt},   {31'h0, v.gnt});
      chk($sformatf("r%0d_re", i),    {31'h0, mem_re},      {31'h0, v.re});
      chk($sformatf("r%0d_we", i),    {31'h0, mem_we},      {31'h0, v.we});
      if (v.re || v.we) chk($sformatf("r%0d_maddr", i), {23'h0, mem_addr}, {23'h0, v.maddr});
      if (v.we) chk($sformatf("r%0d_wdata", i), mem_wdata, v.wdata);
      chk($sformatf("r%0d_fvalid", i), {31'h0, fetch_valid}, {31'h0, v.fv});
      if (v.fv) begin
        chk($sformatf("r%0d_fdata", i), fetch_data, v.fdata);
        chk($sformatf("r%0d_ferr", i),  {31'h0, fetch_err}, {31'h0, v.ferr});
      end
      chk($sformatf("r%0d_ready", i), {31'h0, ld_ready},  {31'h0, v.rdy});
      chk($sformatf("r%0d_hold", i),  {31'h0, core_hold}, {31'h0, v.hold});
      chk($sformatf("r%0d_done", i),  {31'h0, ld_done},   {31'h0, v.done});
      @(negedge clk);
    end

    // Load MEM_DEPTH+1 words: the last one wraps to index 0 and sets ld_overflow
    drive(1'b0, 11'd0, 1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    for (int k = 0; k <= 512; k++) begin
      w = 32'hC0000000 | k;
      exp_q.push_back({9'(k % 512), w});
      for (int b = 0; b < 4; b++) begin
        drive(1'b0, 11'd0, 1'b0, 1'b1, (k == 512 && b == 3), w[31-8*b -: 8]);
        if (b == 0 && k == 511) chk("ovf_before_wrap", {31'h0, ld_overflow}, 32'h0);
        if (b == 0 && k == 512) chk("ovf_after_wrap",  {31'h0, ld_overflow}, 32'h1);
        if (b == 0 && (k == 0 || k == 512)) chk("ovf_ready", {31'h0, ld_ready}, 32'h1);
        @(negedge clk);
      end
      drive(1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 8'h00);
      if (k == 512) chk("wrap_write_addr", {23'h0, mem_addr}, 32'h0);
      @(negedge clk);
    end
    drive(1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("ovf_done", {31'h0, ld_done}, 32'h1);
    chk("ovf_sticky", {31'h0, ld_overflow}, 32'h1);
    @(negedge clk);
    drive(1'b1, 11'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("post_load_gnt", {31'h0, fetch_gnt}, 32'h1);
    @(negedge clk);
    drive(1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("wrap_fetch_valid", {31'h0, fetch_valid}, 32'h1);
    chk("wrap_fetch_data", fetch_data, 32'h000200C0);
    @(negedge clk);

    // New load clears ld_overflow; reset in the middle of a word discards it
    drive(1'b0, 11'd0, 1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    drive(1'b0, 11'd0, 1'b0, 1'b1, 1'b0, 8'h55);
    chk("ovf_cleared", {31'h0, ld_overflow}, 32'h0);
    chk("restart_hold", {31'h0, core_hold}, 32'h1);
    @(negedge clk);
    drive(1'b0, 11'd0, 1'b0, 1'b1, 1'b0, 8'h66);
    @(negedge clk);
    drive(1'b1, 11'd4, 1'b0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b0;
    #1;
    chk("rst_fetch_gnt",   {31'h0, fetch_gnt},   32'h0);
    chk("rst_fetch_valid", {31'h0, fetch_valid}, 32'h0);
    chk("rst_fetch_data",  fetch_data,           32'h0);
    chk("rst_fetch_err",   {31'h0, fetch_err},   32'h0);
    chk("rst_ld_ready",    {31'h0, ld_ready},    32'h0);
    chk("rst_ld_done",     {31'h0, ld_done},     32'h0);
    chk("rst_ld_overflow", {31'h0, ld_overflow}, 32'h0);
    chk("rst_core_hold",   {31'h0, core_hold},   32'h0);
    chk("rst_mem_addr",    {23'h0, mem_addr},    32'h0);
    chk("rst_mem_re",      {31'h0, mem_re},      32'h0);
    chk("rst_mem_we",      {31'h0, mem_we},      32'h0);
    chk("rst_mem_wdata",   mem_wdata,            32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 11'd0, 1'b0, 1'b1, 1'b1, 8'h77);
      chk("post_rst_idle_ready", {31'h0, ld_ready}, 32'h0);
      @(negedge clk);
    end
    chk("exp_q_drained", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
